// File: rtl/operand_sweep_driver_pkg.sv
// Shared types and sizes for the operand sweep exerciser.
// Build with SWEEP_LOG_EN defined to add the per-capture log stream.
package sweep_pkg;

    localparam int NUM_VECTORS = 256;
    localparam int SIG_W       = 16;
    localparam int CNT_W       = 16;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RST     = 3'd1,
        S_SETTLE  = 3'd2,
        S_PULSE   = 3'd3,
        S_RUN     = 3'd4,
        S_CAPTURE = 3'd5,
        S_DONE    = 3'd6
    } state_e;

endpackage

// File: rtl/operand_sweep_driver_if.sv
// Operator-interface bus between the sweep driver and the processor.
// master drives switches/button/reset and samples led.
interface operand_sweep_driver_if;

    logic       dut_resetn;
    logic       btnu;
    logic [3:0] sw_a;
    logic [3:0] sw_b;
    logic [7:0] led;

    modport master (
        output dut_resetn,
        output btnu,
        output sw_a,
        output sw_b,
        input  led
    );

    modport slave (
        input  dut_resetn,
        input  btnu,
        input  sw_a,
        input  sw_b,
        output led
    );

endinterface

// File: rtl/operand_sweep_driver_phase_timer.sv
// Down-counter timing each sweep phase; reloaded on state entry.
// expired is high in the last cycle of the loaded duration.
module phase_timer
    import sweep_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expired = (count == W'(1));

endmodule

// File: rtl/operand_sweep_driver.sv
// Sweeps all {sw_a, sw_b} pairs through the processor and sums led.
// SWEEP_LOG_EN adds log_valid/log_data for streaming each capture.
module operand_sweep_driver
    import sweep_pkg::*;
#(
    parameter int RST_CYCLES    = 9,
    parameter int SETTLE_CYCLES = 12,
    parameter int PULSE_CYCLES  = 5,
    parameter int RUN_CYCLES    = 160
) (
    input  logic                 CLK100MHZ,
    input  logic                 CPU_RESETN,
    input  logic                 start,
    operand_sweep_driver_if.master cpu,
    output logic [7:0]           cur_index,
    output logic                 busy,
    output logic                 done,
`ifdef SWEEP_LOG_EN
    output logic                 log_valid,
    output logic [15:0]          log_data,
`endif
    output logic [SIG_W-1:0]     signature
);

    // The phase counter is 16 bits; reject durations it cannot hold.
    if (RST_CYCLES < 1 || RST_CYCLES > 65535 ||
        SETTLE_CYCLES < 1 || SETTLE_CYCLES > 65535 ||
        PULSE_CYCLES < 1 || PULSE_CYCLES > 65535 ||
        RUN_CYCLES < 1 || RUN_CYCLES > 65535) begin : g_bad_cfg
        $error("operand_sweep_driver: cycle parameter out of range");
    end

    state_e             state;
    state_e             next_state;
    logic               load;
    logic [CNT_W-1:0]   load_val;
    logic               expired;
    logic               accept;
    logic               last;
    logic               dut_resetn_q;
    logic               btnu_q;

    phase_timer #(.W(CNT_W)) u_timer (
        .clk      (CLK100MHZ),
        .rst_n    (CPU_RESETN),
        .load     (load),
        .load_val (load_val),
        .expired  (expired)
    );

    assign accept = start && (state == S_IDLE || state == S_DONE);
    assign last   = (cur_index == 8'(NUM_VECTORS - 1));

    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:    if (start) next_state = S_RST;
            S_RST:     if (expired) next_state = S_SETTLE;
            S_SETTLE:  if (expired) next_state = S_PULSE;
            S_PULSE:   if (expired) next_state = S_RUN;
            S_RUN:     if (expired) next_state = S_CAPTURE;
            S_CAPTURE: next_state = last ? S_DONE : S_RST;
            S_DONE:    if (start) next_state = S_RST;
            default:   next_state = S_IDLE;
        endcase
    end

    always_comb begin
        load     = (next_state != state);
        load_val = CNT_W'(1);
        unique case (next_state)
            S_RST:    load_val = CNT_W'(RST_CYCLES);
            S_SETTLE: load_val = CNT_W'(SETTLE_CYCLES);
            S_PULSE:  load_val = CNT_W'(PULSE_CYCLES);
            S_RUN:    load_val = CNT_W'(RUN_CYCLES);
            default:  load_val = CNT_W'(1);
        endcase
    end

    // Bus levels are decoded from next_state so they register on entry.
    always_ff @(posedge CLK100MHZ or negedge CPU_RESETN) begin
        if (!CPU_RESETN) begin
            dut_resetn_q <= 1'b0;
            btnu_q       <= 1'b0;
            cur_index    <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            signature    <= '0;
        end else begin
            dut_resetn_q <= (next_state != S_RST);
            btnu_q       <= (next_state == S_PULSE);
            if (accept) begin
                cur_index <= '0;
                signature <= '0;
                done      <= 1'b0;
                busy      <= 1'b1;
            end else if (state == S_CAPTURE) begin
                signature <= signature + SIG_W'(cpu.led);
                if (last) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cur_index <= cur_index + 8'd1;
                end
            end
        end
    end

    assign cpu.dut_resetn = dut_resetn_q;
    assign cpu.btnu       = btnu_q;
    assign cpu.sw_a       = cur_index[7:4];
    assign cpu.sw_b       = cur_index[3:0];

`ifdef SWEEP_LOG_EN
    assign log_valid = (state == S_CAPTURE);
    assign log_data  = {cur_index, cpu.led};
`endif

endmodule

// File: tb/tb_operand_sweep_driver.sv
// Scoreboard bench for operand_sweep_driver at default timing.
// Vector indices and final signatures are queued and checked by a monitor.
module tb_operand_sweep_driver;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  cur_index;
    logic        busy;
    logic        done;
    logic [15:0] signature;
`ifdef SWEEP_LOG_EN
    logic        log_valid;
    logic [15:0] log_data;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0]  idx_q[$];
    logic [15:0] sig_q[$];
    int          btnu_viol = 0;

    operand_sweep_driver_if cpu ();

    always #5 clk = ~clk;

    operand_sweep_driver dut (
        .CLK100MHZ  (clk),
        .CPU_RESETN (rst_n),
        .start      (start),
        .cpu        (cpu.master),
        .cur_index  (cur_index),
        .busy       (busy),
        .done       (done),
`ifdef SWEEP_LOG_EN
        .log_valid  (log_valid),
        .log_data   (log_data),
`endif
        .signature  (signature)
    );

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: one vector event per dut_resetn fall, one sweep event per busy fall
    logic prev_dr = 1'b0;
    logic prev_busy = 1'b0;
    logic prev_done = 1'b0;
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (prev_dr && !cpu.dut_resetn) begin
                if (idx_q.size() == 0) begin
                    check("unexpected_vector", {24'h0, cur_index}, 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] e;
                    e = idx_q.pop_front();
                    check("vec_index", {24'h0, cur_index}, {24'h0, e});
                    check("vec_sw", {24'h0, cpu.sw_a, cpu.sw_b}, {24'h0, e});
                end
            end
            if (prev_busy && !busy) begin
                check("done_with_busy_fall", {30'h0, prev_done, done}, 32'h1);
                if (sig_q.size() == 0) begin
                    check("unexpected_sweep_end", {16'h0, signature}, 32'hFFFF_FFFF);
                end else begin
                    logic [15:0] s;
                    s = sig_q.pop_front();
                    check("sweep_signature", {16'h0, signature}, {16'h0, s});
                end
            end
            if (cpu.btnu && !cpu.dut_resetn) btnu_viol++;
        end
        prev_dr   = cpu.dut_resetn;
        prev_busy = busy;
        prev_done = done;
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_index(input logic [7:0] target, input int bound);
        int n;
        n = 0;
        while (cur_index !== target && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("wait_index", {24'h0, cur_index}, {24'h0, target});
    endtask

    initial begin
        int n;
        int sw_bad;
        int idle_bad;
        rst_n   = 1'b0;
        start   = 1'b0;
        cpu.led = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_dut_resetn", {31'h0, cpu.dut_resetn}, 32'h0);
        check("rst_btnu", {31'h0, cpu.btnu}, 32'h0);
        check("rst_sw", {24'h0, cpu.sw_a, cpu.sw_b}, 32'h0);
        check("rst_index", {24'h0, cur_index}, 32'h0);
        check("rst_flags", {30'h0, busy, done}, 32'h0);
        check("rst_signature", {16'h0, signature}, 32'h0);

        rst_n = 1'b1;
        idle_bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (cpu.dut_resetn !== 1'b1 || busy !== 1'b0) idle_bad++;
        end
        check("idle_stable", idle_bad, 0);

        // Sweep A: vector-0 timing, ignored start at 0x37, reset at 0x80
        cpu.led = 8'h01;
        for (int i = 0; i <= 8'h80; i++) idx_q.push_back(8'(i));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sw_bad = 0;
        n = 0;
        while (cpu.dut_resetn === 1'b0 && n < 1000) begin
            if (cpu.sw_a !== 4'h0 || cpu.sw_b !== 4'h0) sw_bad++;
            n++;
            @(negedge clk);
        end
        check("v0_rst_len", n, 9);
        n = 0;
        while (cpu.dut_resetn === 1'b1 && cpu.btnu === 1'b0 && n < 1000) begin
            if (cpu.sw_a !== 4'h0 || cpu.sw_b !== 4'h0) sw_bad++;
            n++;
            @(negedge clk);
        end
        check("v0_settle_len", n, 12);
        n = 0;
        while (cpu.btnu === 1'b1 && n < 1000) begin
            if (cpu.sw_a !== 4'h0 || cpu.sw_b !== 4'h0) sw_bad++;
            n++;
            @(negedge clk);
        end
        check("v0_pulse_len", n, 5);
        n = 0;
        while (signature === 16'h0 && n < 1000) begin
            if (cpu.sw_a !== 4'h0 || cpu.sw_b !== 4'h0) sw_bad++;
            n++;
            @(negedge clk);
        end
        check("v0_run_plus_capture", n, 161);
        check("v0_sw_stable", sw_bad, 0);
        check("v0_first_sum", {16'h0, signature}, 32'h1);

        wait_index(8'h37, 60 * 187);
        repeat (30) @(negedge clk);
        pulse_start();
        repeat (5) @(negedge clk);
        check("busy_start_ignored", {23'h0, busy, cur_index}, 32'h137);
        check("busy_start_sig", {16'h0, signature}, 32'h37);

        wait_index(8'h80, 80 * 187);
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_dut_resetn", {31'h0, cpu.dut_resetn}, 32'h0);
        check("midrst_btnu", {31'h0, cpu.btnu}, 32'h0);
        check("midrst_index", {24'h0, cur_index}, 32'h0);
        check("midrst_flags", {30'h0, busy, done}, 32'h0);
        check("midrst_signature", {16'h0, signature}, 32'h0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_dut_resetn", {31'h0, cpu.dut_resetn}, 32'h1);
        check("sweep_a_vectors_seen", idx_q.size(), 0);

        // Sweep B: full sweep with led=01
        for (int i = 0; i < 256; i++) idx_q.push_back(8'(i));
        sig_q.push_back(16'h0100);
        pulse_start();
        n = 0;
        while (busy === 1'b1 && n < 50000) begin
            n++;
            @(negedge clk);
        end
        check("sweep_len", n, 47872);
        repeat (10) @(negedge clk);
        check("done_sw", {24'h0, cpu.sw_a, cpu.sw_b}, 32'hFF);
        check("done_state", {29'h0, cpu.dut_resetn, busy, done}, 32'h5);
        check("done_sig_hold", {16'h0, signature}, 32'h0100);
        check("sweep_b_vectors_seen", idx_q.size(), 0);
        check("sweep_b_sig_seen", sig_q.size(), 0);

        // Sweep C: restart from DONE with led=FF
        cpu.led = 8'hFF;
        for (int i = 0; i <= 4; i++) idx_q.push_back(8'(i));
        pulse_start();
        check("restart_sig_clear", {16'h0, signature}, 32'h0);
        check("restart_flags", {23'h0, busy, done, cur_index}, 32'h200);
        wait_index(8'h04, 6 * 187);
        check("restart_sum_ff", {16'h0, signature}, 32'h03FC);
        repeat (2) @(negedge clk);
        check("sweep_c_vectors_seen", idx_q.size(), 0);
        check("btnu_never_in_reset", btnu_viol, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/operand_sweep_driver.md
Name: operand_sweep_driver

Overview:
- Synthesizable on-chip exerciser for the microprocessor's operator interface. It is the driving end of the SW_A/SW_B/BTNU/CPU_RESETN interface and the sampling end of LED.
- Sweeps all 256 {SW_A, SW_B} operand pairs. For each pair it resets the processor, pulses the button, waits a run window, then samples LED.
- Folds every LED sample into a 16-bit checksum, giving a board-level self-test with no external stimulus.
- Sits beside the processor instance in the top level; its outputs feed the processor inputs through a mux selected by busy.

Parameters:
RST_CYCLES, 9, cycles dut_resetn held low per vector (>=1)
SETTLE_CYCLES, 12, cycles after dut_resetn release before button press (>=1)
PULSE_CYCLES, 5, cycles btnu held high (>=1)
RUN_CYCLES, 160, cycles after button release before LED capture (>=1)

Ports:
CLK100MHZ  in  1  system clock, 100 MHz
CPU_RESETN  in  1  asynchronous active-low reset
start  in  1  single-cycle request to begin a sweep
led  in  8  processor LED output, sampled at capture
dut_resetn  out  1  active-low reset to the processor
btnu  out  1  button press to the processor
sw_a  out  4  operand A (outer loop)
sw_b  out  4  operand B (inner loop)
cur_index  out  8  {sw_a, sw_b} of the current vector
busy  out  1  high from start acceptance until the last capture
done  out  1  high after a full sweep, held until the next start
signature  out  16  running sum of captured LED values, mod 2^16

Behaviour:
- Reset values: dut_resetn=0 (asserted asynchronously), btnu=0, sw_a=sw_b=0, cur_index=0, busy=0, done=0, signature=0. All outputs are registered.
- States: IDLE, RST, SETTLE, PULSE, RUN, CAPTURE, DONE.
- IDLE: dut_resetn=1, btnu=0. On start: index<=0, signature<=0, done<=0, busy<=1, go to RST.
- RST: dut_resetn=0; sw_a/sw_b = index[7:4]/index[3:0]; hold RST_CYCLES, then go to SETTLE.
- SETTLE: dut_resetn=1; hold SETTLE_CYCLES, then go to PULSE.
- PULSE: btnu=1; hold PULSE_CYCLES, then go to RUN.
- RUN: btnu=0; hold RUN_CYCLES, then go to CAPTURE.
- CAPTURE: one cycle. signature<=signature+{8'h00,led}, wrapping mod 2^16.
  - If index==8'hFF: busy<=0, done<=1, go to DONE.
  - Otherwise: index<=index+1, go to RST.
- DONE: dut_resetn=1; sw_a/sw_b hold 4'hF; signature holds its value.
  - start clears done, clears signature, sets busy and restarts at index 0 (same actions as from IDLE).
- Vector period = RST+SETTLE+PULSE+RUN+1 = 187 cycles at defaults. Full sweep = 256*187 = 47872 cycles from the first RST cycle.
- Switches change only on entry to RST. They stay stable through the whole vector.
- btnu is high for exactly PULSE_CYCLES per vector and is never high while dut_resetn=0.
- start while busy=1 is ignored.
- led is sampled only in CAPTURE. It is treated as synchronous to CLK100MHZ; no synchronizer is required.
- CPU_RESETN asserted mid-sweep: immediate return to reset values; the partial signature is lost. After release the block enters IDLE with dut_resetn=1 from the first clock edge.
- The phase counter is 16 bits wide. Any parameter of 0 or >65535 is an elaboration-time error.

Optional Feature:
- SWEEP_LOG_EN defined:
  - Adds output log_valid (1 bit), high for the single CAPTURE cycle.
  - Adds output log_data (16 bits) = {cur_index, led}, for streaming every sample to a UART/ILA.
- SWEEP_LOG_EN undefined: ports absent, no extra logic.

Decomposition:
- Package sweep_pkg: state enumeration (3-bit encoding), NUM_VECTORS=256, SIG_W=16, CNT_W=16.
- One sub-module, phase_timer:
  - Inputs: load and load value.
  - Counts down and flags expiry.
  - Reloaded on every state entry with the matching *_CYCLES value.
- The top-level FSM owns the index, the signature and all outputs.

Test Plan:
- Reset then idle: with CPU_RESETN low, dut_resetn=0 and all other outputs 0. After release, dut_resetn=1 and busy=0 indefinitely with no start.
- Timing of vector 0: start pulse, then dut_resetn low for 9 cycles, high 12 cycles before btnu rises, btnu high exactly 5 cycles, capture 160 cycles after btnu falls. sw_a=0, sw_b=0 throughout.
- Sweep with led tied to 8'h01: done after 47872 cycles, signature=16'h0100, cur_index sequence 00,01,...,0F,10,...,FF.
- Sweep with led tied to 8'hFF: signature=16'hFF00. busy falls and done rises on the same edge.
- start during busy at vector 0x37: ignored, sweep continues unchanged. start in DONE: signature cleared, new sweep from index 0.
- CPU_RESETN pulsed at vector 0x80: outputs immediately at reset values. A new start gives a clean full sweep with the correct signature.
